// File: rtl/nco_sample_dac.sv
// nco_sample_dac
//   Fetches one sample per PWM period from the NCO and plays it as a 1-bit
//   PWM duty cycle for the board's audio filter.
//
//   The NCO is paced with a one-cycle next_sample pulse at cnt == P-3.
//   Its two's-complement code is captured at the end of cycle P-2.
//   At the wrap, the captured code becomes the offset-binary duty for the
//   next period.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           play enable, only looked at on the wrap edge
//   code         NCO sample, two's complement, must be stable in cycle P-2
//   next_sample  one-cycle fetch request to the NCO
//   pwm          registered PWM output
//   duty         duty register driving the current period (debug)

module nco_sample_dac #(
  parameter int CODE_WIDTH = 14,
  parameter int DAC_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [CODE_WIDTH-1:0] code,
  output logic                  next_sample,
  output logic                  pwm,
  output logic [DAC_WIDTH-1:0]  duty
);

  if (DAC_WIDTH < 4 || DAC_WIDTH > CODE_WIDTH) begin : g_bad_params
    $error("nco_sample_dac: DAC_WIDTH must satisfy 4 <= DAC_WIDTH <= CODE_WIDTH");
  end

  // Period landmarks: P-1, P-2, P-3 and the idle mid-scale duty.
  localparam logic [DAC_WIDTH-1:0] CNT_LAST    = '1;
  localparam logic [DAC_WIDTH-1:0] CNT_CAPTURE = {{(DAC_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [DAC_WIDTH-1:0] CNT_FETCH   = {{(DAC_WIDTH-2){1'b1}}, 2'b01};
  localparam logic [DAC_WIDTH-1:0] MID         = {1'b1, {(DAC_WIDTH-1){1'b0}}};

  logic [DAC_WIDTH-1:0]  cnt;
  logic                  en_q;
  logic [CODE_WIDTH-1:0] pending;
  logic [DAC_WIDTH-1:0]  conv_code;

  // Two's complement to offset binary: flip the sign bit, then keep the top
  // magnitude bits. The remaining LSBs are deliberately truncated.
  assign conv_code = {~pending[CODE_WIDTH-1], pending[CODE_WIDTH-2 -: DAC_WIDTH-1]};

  // The truncated LSBs are stored but never read.
  if (CODE_WIDTH > DAC_WIDTH) begin : g_trunc
    logic unused_lsbs;
    assign unused_lsbs = ^pending[CODE_WIDTH-DAC_WIDTH-1:0];
  end

  // Decoded purely from registers, so the pulse is glitch-free.
  // It cannot fire while playback is disabled.
  assign next_sample = en_q && (cnt == CNT_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      en_q    <= 1'b0;
      pending <= '0;
      duty    <= MID;
      pwm     <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      pwm <= (cnt < duty);
      // The NCO advanced on the previous edge, so code now holds the new sample.
      if (en_q && (cnt == CNT_CAPTURE)) begin
        pending <= code;
      end
      // duty only moves here, so a whole PWM period uses a single value.
      if (cnt == CNT_LAST) begin
        duty <= en_q ? conv_code : MID;
        en_q <= en;
      end
    end
  end

endmodule

// File: tb/tb_nco_sample_dac.sv
module tb_nco_sample_dac;

  localparam int         P   = 1024;
  localparam logic [9:0] MID = 10'd512;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        en    = 1'b0;
  logic [13:0] code  = '0;
  logic        next_sample;
  logic        pwm;
  logic [9:0]  duty;

  always #5 clk = ~clk;

  nco_sample_dac #(.CODE_WIDTH(14), .DAC_WIDTH(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .code        (code),
    .next_sample (next_sample),
    .pwm         (pwm),
    .duty        (duty)
  );

  int checks = 0;
  int errors = 0;

  // Bench-side view of the period position and the expected duty.
  int          tcnt;
  int          tabs;
  logic [9:0]  exp_duty;
  logic [13:0] cur_code;
  logic [9:0]  sb_q[$];   // expected duty per fetch, popped at the wrap
  logic [13:0] nco_q[$];  // stub NCO sample sequence

  int pulses, pulse_pos_err, spacing_err, first_pulse_abs, last_pulse_abs;
  int pwm_err, per_high, period_high;

  function automatic logic [9:0] conv(input logic [13:0] v);
    return {~v[13], v[12:4]};
  endfunction

  // One clock: sample outputs 1 ns after the edge, run the scoreboard and the
  // stub NCO, then drive code for the new cycle.
  task automatic tick();
    logic exp_pwm;
    exp_pwm = (tcnt < int'(exp_duty));
    @(posedge clk);
    #1;
    tcnt = (tcnt + 1) % P;
    tabs++;
    if (pwm !== exp_pwm) pwm_err++;
    per_high += int'(pwm);
    if (tcnt == 0) begin
      period_high = per_high;
      per_high    = 0;
      exp_duty    = (sb_q.size() > 0) ? sb_q.pop_front() : MID;
      checks++;
      if (duty !== exp_duty) begin
        errors++;
        $display("FAIL duty_sb at cycle %0d: got %0d expected %0d", tabs, duty, exp_duty);
      end
    end
    if (next_sample === 1'b1) begin
      pulses++;
      if (tcnt != P-3) pulse_pos_err++;
      if (last_pulse_abs >= 0 && (tabs - last_pulse_abs) != P) spacing_err++;
      if (first_pulse_abs < 0) first_pulse_abs = tabs;
      last_pulse_abs = tabs;
      if (nco_q.size() > 0) cur_code = nco_q.pop_front();
      sb_q.push_back(conv(cur_code));
    end
    // Only cycle P-2 carries the real sample; every other cycle gets junk.
    code = (tcnt == P-2) ? cur_code : (cur_code ^ 14'($urandom_range(1, 16383)));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_stats();
    pulses = 0; pulse_pos_err = 0; spacing_err = 0; pwm_err = 0;
  endtask

  task automatic release_reset(input logic en_val);
    en = en_val;
    @(negedge clk);
    tcnt = 0; tabs = 0; exp_duty = MID; cur_code = '0;
    sb_q.delete(); nco_q.delete();
    per_high = 0; period_high = 0;
    first_pulse_abs = -1; last_pulse_abs = -1;
    clear_stats();
    code  = 14'($urandom_range(1, 16383));
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (duty !== MID) begin errors++; $display("FAIL reset_duty: got %0d expected %0d", duty, MID); end
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b expected 0", pwm); end
    checks++; if (next_sample !== 1'b0) begin errors++; $display("FAIL reset_next_sample: got %b expected 0", next_sample); end
    release_reset(1'b0);
  endtask

  task automatic test_idle();
    clear_stats();
    for (int p = 0; p < 3; p++) begin
      run(P);
      checks++;
      if (period_high != 512) begin errors++; $display("FAIL idle_pwm_high period %0d: got %0d expected 512", p, period_high); end
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL idle_pulses: got %0d expected 0", pulses); end
    checks++; if (pwm_err != 0) begin errors++; $display("FAIL idle_pwm_cycles: got %0d bad cycles expected 0", pwm_err); end
    checks++; if (duty !== MID) begin errors++; $display("FAIL idle_duty: got %0d expected 512", duty); end
  endtask

  task automatic test_en_rise();
    rst_n = 1'b0;
    #2;
    release_reset(1'b1);
    nco_q.push_back(14'h0019);
    run(2048);
    checks++; if (first_pulse_abs != 1024 + 1021) begin errors++; $display("FAIL rise_first_pulse: got %0d expected %0d", first_pulse_abs, 1024 + 1021); end
    checks++; if (duty !== 10'd513) begin errors++; $display("FAIL rise_duty: got %0d expected 513", duty); end
    run(2048);
    checks++; if (pulses != 3) begin errors++; $display("FAIL rise_pulse_count: got %0d expected 3", pulses); end
    checks++; if (spacing_err != 0) begin errors++; $display("FAIL rise_spacing: got %0d bad gaps expected 0", spacing_err); end
    checks++; if (pulse_pos_err != 0) begin errors++; $display("FAIL rise_pulse_pos: got %0d misplaced expected 0", pulse_pos_err); end
    checks++; if (pwm_err != 0) begin errors++; $display("FAIL rise_pwm_cycles: got %0d bad cycles expected 0", pwm_err); end
  endtask

  task automatic test_extremes();
    clear_stats();
    nco_q.push_back(14'h1FFF);
    nco_q.push_back(14'h2000);
    nco_q.push_back(14'h3FF0);
    run(P);
    checks++; if (duty !== 10'd1023) begin errors++; $display("FAIL ext_max_duty: got %0d expected 1023", duty); end
    run(P);
    checks++; if (period_high != 1023) begin errors++; $display("FAIL ext_max_pwm_high: got %0d expected 1023", period_high); end
    checks++; if (duty !== 10'd0) begin errors++; $display("FAIL ext_min_duty: got %0d expected 0", duty); end
    run(P);
    checks++; if (period_high != 0) begin errors++; $display("FAIL ext_min_pwm_high: got %0d expected 0", period_high); end
    checks++; if (duty !== 10'd511) begin errors++; $display("FAIL ext_neg16_duty: got %0d expected 511", duty); end
    run(P);
    checks++; if (period_high != 511) begin errors++; $display("FAIL ext_neg16_pwm_high: got %0d expected 511", period_high); end
    checks++; if (pwm_err != 0) begin errors++; $display("FAIL ext_pwm_cycles: got %0d bad cycles expected 0", pwm_err); end
  endtask

  task automatic test_code_window();
    clear_stats();
    nco_q.push_back(14'h1000);
    run(P);
    checks++; if (duty !== 10'd768) begin errors++; $display("FAIL window_duty: got %0d expected 768", duty); end
    run(P);
    checks++; if (period_high != 768) begin errors++; $display("FAIL window_pwm_high: got %0d expected 768", period_high); end
  endtask

  task automatic test_en_toggle();
    clear_stats();
    nco_q.push_back(14'h0800);
    nco_q.push_back(14'h3000);
    run(100); en = 1'b0;
    run(P - 100);
    checks++; if (duty !== 10'd640) begin errors++; $display("FAIL toggle_last_duty: got %0d expected 640", duty); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL toggle_fetch_before_off: got %0d expected 1", pulses); end
    pulses = 0;
    run(200); en = 1'b1;
    run(100); en = 1'b0;
    run(P - 300);
    checks++; if (period_high != 640) begin errors++; $display("FAIL toggle_last_plays: got %0d expected 640", period_high); end
    checks++; if (duty !== MID) begin errors++; $display("FAIL toggle_mid_after: got %0d expected 512", duty); end
    run(100); en = 1'b1;
    run(P - 100);
    checks++; if (period_high != 512) begin errors++; $display("FAIL toggle_mid_plays: got %0d expected 512", period_high); end
    checks++; if (duty !== MID) begin errors++; $display("FAIL toggle_rise_mid: got %0d expected 512", duty); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL toggle_no_fetch_off: got %0d expected 0", pulses); end
    run(P);
    checks++; if (duty !== 10'd256) begin errors++; $display("FAIL toggle_resume_duty: got %0d expected 256", duty); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL toggle_resume_fetch: got %0d expected 1", pulses); end
    run(P);
    checks++; if (period_high != 256) begin errors++; $display("FAIL toggle_resume_plays: got %0d expected 256", period_high); end
    checks++; if (pwm_err != 0) begin errors++; $display("FAIL toggle_pwm_cycles: got %0d bad cycles expected 0", pwm_err); end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (tcnt != P-2 && guard < 2*P) begin
      tick();
      guard++;
    end
    checks++; if (tcnt != P-2) begin errors++; $display("FAIL midrst_reach_capture: got %0d expected %0d", tcnt, P-2); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (duty !== MID) begin errors++; $display("FAIL midrst_duty: got %0d expected 512", duty); end
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL midrst_pwm: got %b expected 0", pwm); end
    checks++; if (next_sample !== 1'b0) begin errors++; $display("FAIL midrst_next_sample: got %b expected 0", next_sample); end
    #20;
    release_reset(1'b1);
    nco_q.push_back(14'h0019);
    run(2048);
    checks++; if (first_pulse_abs != 1024 + 1021) begin errors++; $display("FAIL midrst_first_pulse: got %0d expected %0d", first_pulse_abs, 1024 + 1021); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL midrst_pulse_count: got %0d expected 1", pulses); end
    checks++; if (duty !== 10'd513) begin errors++; $display("FAIL midrst_duty_after: got %0d expected 513", duty); end
    checks++; if (pwm_err != 0) begin errors++; $display("FAIL midrst_pwm_cycles: got %0d bad cycles expected 0", pwm_err); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_en_rise();
    test_extremes();
    test_code_window();
    test_en_toggle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nco_sample_dac.md
# nco_sample_dac

Audio-rate consumer of the NCO sample stream. It paces sample fetches with a single-cycle `next_sample` pulse once per PWM period and captures the NCO's 14-bit two's-complement `code` one cycle later. It converts each captured code to an offset-binary duty cycle and drives a 1-bit PWM output to the board's audio filter. It sits between `nco` and the audio pin: the NCO is the sample producer and this block is the sample fetcher.

## Interface
- `CODE_WIDTH`, default 14: width of the NCO sample.
- `DAC_WIDTH`, default 10: PWM resolution. Period P = 2^DAC_WIDTH cycles (1024 cycles gives ≈122.07 kHz at 125 MHz). Requires 4 ≤ DAC_WIDTH ≤ CODE_WIDTH.
- `clk`  in  1  system clock, 125 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  play enable; sampled only at period wrap.
- `code`  in  CODE_WIDTH  NCO sample, two's complement.
- `next_sample`  out  1  one-cycle fetch request to the NCO.
- `pwm`  out  1  PWM audio output, registered.
- `duty`  out  DAC_WIDTH  current duty register, for debug/verification.

## Operation
- Registers:
  - `cnt` (DAC_WIDTH bits): free-running 0..P-1, wraps to 0.
  - `en_q`: enable latched at wrap.
  - `pending` (CODE_WIDTH bits): captured sample.
  - `duty` (DAC_WIDTH bits).
  - `pwm`.
- `next_sample` = en_q && (cnt == P-3). It is decoded from registers, so it is glitch-free and exactly one cycle wide per period. It is never high while en_q = 0.
- Capture: on the edge ending cycle cnt == P-2, `pending <= code` if en_q. Otherwise `pending` holds.
- Wrap edge (ending cycle cnt == P-1):
  - `duty <= en_q ? conv(pending) : MID`, where MID = 2^(DAC_WIDTH-1).
  - `en_q <= en`.
- conv(c) = {~c[CODE_WIDTH-1], c[CODE_WIDTH-2 -: DAC_WIDTH-1]}, i.e. the sign bit is inverted and lower bits are truncated. There is no rounding and no saturation.
- PWM: every edge, `pwm <= (cnt < duty)` using the pre-edge values. Duty 0 gives pwm always low. Duty P-1 gives pwm high for P-1 of P cycles.
- Enable behaviour:
  - en rising: the first period after the wrap plays MID and fetches a sample. The following period plays that sample.
  - en falling: the period after the wrap does not fetch but still plays the last captured sample. After that, MID is played.
- `en` changes that occur away from the wrap have no effect until the wrap.

## Timing
- Reset (async assert, sync-safe deassert handled upstream):
  - `cnt` = 0, `en_q` = 0, `pending` = 0, `duty` = MID, `pwm` = 0, `next_sample` = 0.
  - Reset mid-period aborts everything immediately. Any in-flight fetch is dropped, and the NCO phase may already have advanced; this is acceptable.
- Fetch handshake, per period:
  - cycle P-3: `next_sample` is high, and the NCO advances on the edge ending this cycle.
  - cycle P-2: `code` shows the new sample and is captured on the edge ending this cycle.
  - cycle P-1: idle.
  - wrap edge: the new duty is loaded.
- Latency from the `next_sample` pulse to the new `duty` is 3 cycles. From `duty` update to the first `pwm` reflecting it is 1 cycle. The sample rate is exactly clk/P, independent of `code`.
- `code` must be stable throughout cycle P-2. It is don't-care in all other cycles.
- `duty` changes only at the wrap edge, so each PWM period uses a single duty value.

## Test plan
- Reset then idle, en = 0 for 3 periods:
  - `next_sample` never asserts.
  - `duty` = 512.
  - `pwm` is high for exactly 512 of every 1024 cycles.
- en = 1 from reset, with the stub NCO returning code = 14'h0019 (25) after the first pulse:
  - first pulse at absolute cycle 1024+1021.
  - `duty` = 513 from the wrap at cycle 2048.
  - pulses are spaced exactly 1024 cycles apart.
- Extremes with en = 1:
  - code = 14'h1FFF gives duty 1023, and pwm is low for exactly 1 cycle per period.
  - code = 14'h2000 gives duty 0, and pwm stays low.
  - code = 14'h3FF0 (−16) gives duty 511.
- Stub NCO changes `code` during cycles P-3 and P-1 but holds 14'h1000 in cycle P-2:
  - `duty` = 768.
  - the cycle P-3 and P-1 values are ignored.
- Toggle en low at cycle 100 of an active period, then high again 2 periods later:
  - no fetch in the periods with en_q = 0.
  - the last sample plays for one period, then 512, and playback resumes as specified for en rising.
  - `en` pulses that do not span a wrap are ignored.
- Assert rst_n low at cycle P-2 during capture:
  - all outputs go to reset values immediately, without waiting for a clock edge.
  - after release, the first `next_sample` pulse occurs after the first wrap at which en = 1 is latched, at cycle P-3 of the following period.
